// File: rtl/cp0_exc_ctrl_pkg.sv
// rtl/cp0_exc_ctrl_pkg.sv - shared CP0 constants: exception codes, register numbers, field positions
//
// Purpose: one place for the CP0 encodings used by the exception controller
//          and its arbiter.
// Ports:   none (package).
package cp0_exc_ctrl_pkg;

  // Exception codes as carried down the pipeline in exc_code_m.
  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;
  localparam logic [4:0] EXC_NONE = 5'd31;

  // CP0 register numbers.
  localparam logic [4:0] CP0_SR    = 5'd12;
  localparam logic [4:0] CP0_CAUSE = 5'd13;
  localparam logic [4:0] CP0_EPC   = 5'd14;
  localparam logic [4:0] CP0_PRID  = 5'd15;

  // Field bit positions inside SR / Cause.
  localparam int IE_BIT  = 0;
  localparam int EXL_BIT = 1;
  localparam int IM_LO   = 10;
  localparam int EXC_LO  = 2;
  localparam int BD_BIT  = 31;

  localparam int INT_W_DEFAULT = 6;

endpackage

// File: rtl/cp0_exc_ctrl_if.sv
// rtl/cp0_exc_ctrl_if.sv - M-stage to CP0 bus and IF-stage redirect signals
//
// Purpose: groups the M-stage request signals and the CP0 responses.
// Signals: m_valid, pc_m, bd_m, exc_code_m, eret_m, mtc0_en, cp0_addr,
//          cp0_wdata (pipeline -> CP0); err_signal, eret_en, epc_data,
//          cp0_rdata (CP0 -> pipeline).
// Modports: master = pipeline side, slave = CP0 side.
interface cp0_exc_ctrl_if;

  logic        m_valid;
  logic [31:0] pc_m;
  logic        bd_m;
  logic [4:0]  exc_code_m;
  logic        eret_m;
  logic        mtc0_en;
  logic [4:0]  cp0_addr;
  logic [31:0] cp0_wdata;
  logic        err_signal;
  logic        eret_en;
  logic [31:0] epc_data;
  logic [31:0] cp0_rdata;

  modport master (
    output m_valid, pc_m, bd_m, exc_code_m, eret_m, mtc0_en, cp0_addr, cp0_wdata,
    input  err_signal, eret_en, epc_data, cp0_rdata
  );

  modport slave (
    input  m_valid, pc_m, bd_m, exc_code_m, eret_m, mtc0_en, cp0_addr, cp0_wdata,
    output err_signal, eret_en, epc_data, cp0_rdata
  );

endinterface

// File: rtl/cp0_exc_ctrl_arbiter.sv
// rtl/cp0_exc_ctrl_arbiter.sv - combinational interrupt/exception/eret arbitration
//
// Purpose: decides whether the M-stage instruction takes an interrupt, an
//          exception or an eret this cycle, and which ExcCode is recorded.
// Ports:   reset_i       - holds both redirects low while in reset
//          m_valid_i     - M stage holds a real instruction
//          exc_code_m_i  - accumulated exception code (31 = none)
//          eret_m_i      - M-stage instruction is eret
//          sr_ie_i/sr_exl_i/sr_im_i - current SR fields
//          cause_ip_i    - current Cause.IP (registered interrupt lines)
//          exc_code_o    - code to record in Cause.ExcCode
//          err_signal_o  - take exception/interrupt
//          eret_en_o     - perform eret
module cp0_exc_arbiter
  import cp0_exc_ctrl_pkg::*;
#(
  parameter int INT_WIDTH = INT_W_DEFAULT
) (
  input  logic                 reset_i,
  input  logic                 m_valid_i,
  input  logic [4:0]           exc_code_m_i,
  input  logic                 eret_m_i,
  input  logic                 sr_ie_i,
  input  logic                 sr_exl_i,
  input  logic [INT_WIDTH-1:0] sr_im_i,
  input  logic [INT_WIDTH-1:0] cause_ip_i,
  output logic [4:0]           exc_code_o,
  output logic                 err_signal_o,
  output logic                 eret_en_o
);

  logic int_req;
  logic exc_req;

  // Interrupts are only taken on a real instruction so EPC always points at
  // something restartable; EXL masks them while a handler runs.
  assign int_req = m_valid_i & sr_ie_i & ~sr_exl_i & (|(cause_ip_i & sr_im_i));
  assign exc_req = m_valid_i & (exc_code_m_i != EXC_NONE);

  assign exc_code_o   = int_req ? EXC_INT : exc_code_m_i;
  assign err_signal_o = ~reset_i & (int_req | exc_req);
  assign eret_en_o    = ~reset_i & eret_m_i & m_valid_i & ~(int_req | exc_req);

endmodule

// File: rtl/cp0_exc_ctrl.sv
// rtl/cp0_exc_ctrl.sv - CP0 register file and exception controller
//
// Purpose: holds SR/Cause/EPC, records exceptions and interrupts taken in
//          the M stage, clears EXL on eret, services mtc0/mfc0 and drives the
//          IF-stage redirect signals.
// Ports:   clk    - clock
//          reset  - synchronous, active-high
//          hw_int - external interrupt lines, level-sensitive
//          bus    - cp0_exc_ctrl_if.slave (M-stage request, redirect, mfc0 data)
module cp0_exc_ctrl
  import cp0_exc_ctrl_pkg::*;
#(
  parameter logic [31:0] PRID_VALUE = 32'h2020_0707,
  parameter int          INT_WIDTH  = INT_W_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [INT_WIDTH-1:0] hw_int,
  cp0_exc_ctrl_if.slave        bus
);

  logic                 sr_ie_q, sr_ie_d;
  logic                 sr_exl_q, sr_exl_d;
  logic [INT_WIDTH-1:0] sr_im_q, sr_im_d;
  logic                 cause_bd_q, cause_bd_d;
  logic [INT_WIDTH-1:0] cause_ip_q, cause_ip_d;
  logic [4:0]           cause_exc_q, cause_exc_d;
  logic [31:0]          epc_q, epc_d;

  logic [4:0]  exc_code;
  logic        err_signal;
  logic        eret_en;
  logic [31:0] victim_pc;
  logic [31:0] sr_word;
  logic [31:0] cause_word;

  cp0_exc_arbiter #(.INT_WIDTH(INT_WIDTH)) u_arbiter (
    .reset_i      (reset),
    .m_valid_i    (bus.m_valid),
    .exc_code_m_i (bus.exc_code_m),
    .eret_m_i     (bus.eret_m),
    .sr_ie_i      (sr_ie_q),
    .sr_exl_i     (sr_exl_q),
    .sr_im_i      (sr_im_q),
    .cause_ip_i   (cause_ip_q),
    .exc_code_o   (exc_code),
    .err_signal_o (err_signal),
    .eret_en_o    (eret_en)
  );

  // A delay-slot victim restarts at its branch so the branch is re-executed.
  assign victim_pc = bus.bd_m ? (bus.pc_m - 32'd4) : bus.pc_m;

  always_comb begin
    sr_ie_d     = sr_ie_q;
    sr_exl_d    = sr_exl_q;
    sr_im_d     = sr_im_q;
    cause_bd_d  = cause_bd_q;
    cause_exc_d = cause_exc_q;
    epc_d       = epc_q;
    // IP tracks the lines every cycle, independent of any other write.
    cause_ip_d  = hw_int;

    if (err_signal) begin
      sr_exl_d    = 1'b1;
      cause_exc_d = exc_code;
      // Nested exceptions keep the original return point.
      if (!sr_exl_q) begin
        epc_d      = {victim_pc[31:2], 2'b00};
        cause_bd_d = bus.bd_m;
      end
    end else if (eret_en) begin
      sr_exl_d = 1'b0;
    end else if (bus.mtc0_en) begin
      case (bus.cp0_addr)
        CP0_SR: begin
          sr_im_d  = bus.cp0_wdata[IM_LO +: INT_WIDTH];
          sr_exl_d = bus.cp0_wdata[EXL_BIT];
          sr_ie_d  = bus.cp0_wdata[IE_BIT];
        end
        CP0_EPC: epc_d = {bus.cp0_wdata[31:2], 2'b00};
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sr_ie_q     <= 1'b0;
      sr_exl_q    <= 1'b0;
      sr_im_q     <= '0;
      cause_bd_q  <= 1'b0;
      cause_ip_q  <= '0;
      cause_exc_q <= 5'd0;
      epc_q       <= 32'd0;
    end else begin
      sr_ie_q     <= sr_ie_d;
      sr_exl_q    <= sr_exl_d;
      sr_im_q     <= sr_im_d;
      cause_bd_q  <= cause_bd_d;
      cause_ip_q  <= cause_ip_d;
      cause_exc_q <= cause_exc_d;
      epc_q       <= epc_d;
    end
  end

  always_comb begin
    sr_word                        = 32'd0;
    sr_word[IM_LO +: INT_WIDTH]    = sr_im_q;
    sr_word[EXL_BIT]               = sr_exl_q;
    sr_word[IE_BIT]                = sr_ie_q;
    cause_word                     = 32'd0;
    cause_word[BD_BIT]             = cause_bd_q;
    cause_word[IM_LO +: INT_WIDTH] = cause_ip_q;
    cause_word[EXC_LO +: 5]        = cause_exc_q;
  end

  always_comb begin
    case (bus.cp0_addr)
      CP0_SR:    bus.cp0_rdata = sr_word;
      CP0_CAUSE: bus.cp0_rdata = cause_word;
      CP0_EPC:   bus.cp0_rdata = epc_q;
      CP0_PRID:  bus.cp0_rdata = PRID_VALUE;
      default:   bus.cp0_rdata = 32'd0;
    endcase
  end

  assign bus.err_signal = err_signal;
  assign bus.eret_en    = eret_en;
  assign bus.epc_data   = reset ? 32'd0 : epc_q;

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// tb/tb_cp0_exc_ctrl.sv - scoreboard bench for cp0_exc_ctrl
module tb_cp0_exc_ctrl;

  typedef struct {
    string       name;
    logic        err;
    logic        eret;
    logic [31:0] epc;
    logic [31:0] rdata;
  } exp_t;

  logic       clk;
  logic       reset;
  logic [5:0] hw_int;
  logic       rst_v;

  int n_checks;
  int n_errors;

  exp_t sb[$];

  cp0_exc_ctrl_if bus();

  cp0_exc_ctrl #(.PRID_VALUE(32'h2020_0707), .INT_WIDTH(6)) dut (
    .clk    (clk),
    .reset  (reset),
    .hw_int (hw_int),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one M-stage cycle just after the posedge and queue the outputs
  // expected for that same cycle.
  task automatic step(input string name,
                      input logic mv, input logic [31:0] pc, input logic bd,
                      input logic [4:0] exc, input logic eret,
                      input logic mtc0, input logic [4:0] addr,
                      input logic [31:0] wdata, input logic [5:0] hw,
                      input logic e_err, input logic e_eret,
                      input logic [31:0] e_epc, input logic [31:0] e_rdata);
    exp_t e;
    @(posedge clk);
    #1;
    reset          = rst_v;
    bus.m_valid    = mv;
    bus.pc_m       = pc;
    bus.bd_m       = bd;
    bus.exc_code_m = exc;
    bus.eret_m     = eret;
    bus.mtc0_en    = mtc0;
    bus.cp0_addr   = addr;
    bus.cp0_wdata  = wdata;
    hw_int         = hw;
    e.name  = name;
    e.err   = e_err;
    e.eret  = e_eret;
    e.epc   = e_epc;
    e.rdata = e_rdata;
    sb.push_back(e);
  endtask

  // Monitor: every output sample is checked against the oldest queued entry.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      n_checks++;
      if (bus.err_signal !== e.err || bus.eret_en !== e.eret ||
          bus.epc_data !== e.epc || bus.cp0_rdata !== e.rdata) begin
        n_errors++;
        $display("FAIL %s: got err=%b eret=%b epc=%h rdata=%h, expected err=%b eret=%b epc=%h rdata=%h",
                 e.name, bus.err_signal, bus.eret_en, bus.epc_data, bus.cp0_rdata,
                 e.err, e.eret, e.epc, e.rdata);
      end
    end
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_v = 1'b1;
    reset = 1'b1;
    hw_int = 6'd0;
    bus.m_valid = 1'b0; bus.pc_m = 32'd0; bus.bd_m = 1'b0; bus.exc_code_m = 5'd31;
    bus.eret_m = 1'b0; bus.mtc0_en = 1'b0; bus.cp0_addr = 5'd0; bus.cp0_wdata = 32'd0;

    //      name          mv  pc        bd  exc  eret mtc0 addr wdata        hw  err eret epc       rdata
    step("rst_gate",      1, 32'h0,    0,  4,   1,   0,   12, 32'h0,       0,  0,  0,  32'h0,    32'h0);
    step("rst_cause",     0, 32'h0,    0,  31,  0,   0,   13, 32'h0,       0,  0,  0,  32'h0,    32'h0);
    rst_v = 1'b0;
    step("rd_epc",        0, 32'h0,    0,  31,  0,   0,   14, 32'h0,       0,  0,  0,  32'h0,    32'h0);
    step("rd_prid",       0, 32'h0,    0,  31,  0,   0,   15, 32'h0,       0,  0,  0,  32'h0,    32'h2020_0707);
    step("exc_adel",      1, 32'h3010, 0,  4,   0,   0,   13, 32'h0,       0,  1,  0,  32'h0,    32'h0);
    step("exc_cause",     0, 32'h0,    0,  31,  0,   0,   13, 32'h0,       0,  0,  0,  32'h3010, 32'h10);
    step("exc_sr",        0, 32'h0,    0,  31,  0,   0,   12, 32'h0,       0,  0,  0,  32'h3010, 32'h2);
    step("eret1",         1, 32'h0,    0,  31,  1,   0,   12, 32'h0,       0,  0,  1,  32'h3010, 32'h2);
    step("eret1_sr",      0, 32'h0,    0,  31,  0,   0,   12, 32'h0,       0,  0,  0,  32'h3010, 32'h0);
    step("bd_exc",        1, 32'h3024, 1,  12,  0,   0,   14, 32'h0,       0,  1,  0,  32'h3010, 32'h3010);
    step("bd_cause",      0, 32'h0,    0,  31,  0,   0,   13, 32'h0,       0,  0,  0,  32'h3020, 32'h8000_0030);
    step("bd_eret",       1, 32'h0,    0,  31,  1,   0,   12, 32'h0,       0,  0,  1,  32'h3020, 32'h2);
    step("bd_eret_sr",    0, 32'h0,    0,  31,  0,   0,   12, 32'h0,       0,  0,  0,  32'h3020, 32'h0);
    step("mtc0_sr",       1, 32'h0,    0,  31,  0,   1,   12, 32'h401,     0,  0,  0,  32'h3020, 32'h0);
    step("sr_401",        0, 32'h0,    0,  31,  0,   0,   12, 32'h0,       1,  0,  0,  32'h3020, 32'h401);
    step("int_vs_ri",     1, 32'h3030, 0,  10,  0,   0,   13, 32'h0,       1,  1,  0,  32'h3020, 32'h8000_0430);
    step("int_cause",     0, 32'h0,    0,  31,  0,   0,   13, 32'h0,       1,  0,  0,  32'h3030, 32'h400);
    step("int_exl_mask",  1, 32'h3034, 0,  31,  0,   0,   12, 32'h0,       1,  0,  0,  32'h3030, 32'h403);
    step("int_eret",      1, 32'h0,    0,  31,  1,   0,   12, 32'h0,       0,  0,  1,  32'h3030, 32'h403);
    step("mtc0_ie0",      1, 32'h0,    0,  31,  0,   1,   12, 32'h400,     0,  0,  0,  32'h3030, 32'h401);
    step("ip_lag",        1, 32'h0,    0,  31,  0,   0,   12, 32'h0,       1,  0,  0,  32'h3030, 32'h400);
    step("int_ie0",       1, 32'h0,    0,  31,  0,   0,   12, 32'h0,       1,  0,  0,  32'h3030, 32'h400);
    step("mtc0_im0",      1, 32'h0,    0,  31,  0,   1,   12, 32'h001,     1,  0,  0,  32'h3030, 32'h400);
    step("int_im0",       1, 32'h0,    0,  31,  0,   0,   13, 32'h0,       1,  0,  0,  32'h3030, 32'h400);
    step("mtc0_sr2",      1, 32'h0,    0,  31,  0,   1,   12, 32'h401,     1,  0,  0,  32'h3030, 32'h001);
    step("bubble",        0, 32'h0,    0,  4,   1,   0,   12, 32'h0,       0,  0,  0,  32'h3030, 32'h401);
    step("exc_vs_mtc0",   1, 32'h3040, 0,  5,   0,   1,   14, 32'h5554,    0,  1,  0,  32'h3030, 32'h3030);
    step("mtc0_dropped",  0, 32'h0,    0,  31,  0,   0,   14, 32'h0,       0,  0,  0,  32'h3040, 32'h3040);
    step("nested_exc",    1, 32'h3050, 0,  10,  0,   0,   13, 32'h0,       0,  1,  0,  32'h3040, 32'h14);
    step("nested_epc",    0, 32'h0,    0,  31,  0,   0,   14, 32'h0,       0,  0,  0,  32'h3040, 32'h3040);
    step("nested_cause",  0, 32'h0,    0,  31,  0,   0,   13, 32'h0,       0,  0,  0,  32'h3040, 32'h28);
    step("mtc0_epc",      1, 32'h0,    0,  31,  0,   1,   14, 32'h3047,    0,  0,  0,  32'h3040, 32'h3040);
    step("eret_new_epc",  1, 32'h0,    0,  31,  1,   0,   14, 32'h0,       0,  0,  1,  32'h3044, 32'h3044);
    step("exc_3040",      1, 32'h3040, 0,  4,   0,   0,   12, 32'h0,       0,  1,  0,  32'h3044, 32'h401);
    rst_v = 1'b1;
    step("rst_mid",       1, 32'h3048, 0,  4,   1,   0,   12, 32'h0,       0,  0,  0,  32'h0,    32'h403);
    rst_v = 1'b0;
    step("post_rst_sr",   0, 32'h0,    0,  31,  0,   0,   12, 32'h0,       0,  0,  0,  32'h0,    32'h0);
    step("post_rst_cause",0, 32'h0,    0,  31,  0,   0,   13, 32'h0,       0,  0,  0,  32'h0,    32'h0);
    step("post_rst_epc",  0, 32'h0,    0,  4,   0,   0,   14, 32'h0,       0,  0,  0,  32'h0,    32'h0);

    for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
    if (sb.size() > 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
